// File: rtl/if_id_queue_if.sv
// IF/ID queue handshake bundle: fetch push port and decode head port.
interface if_id_queue_if #(
    parameter int n = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [n-1:0]  PC_Counter_output_in;
    logic [31:0]   Instruction_memory_in;
    logic          out_valid;
    logic          out_ready;
    logic [n-1:0]  PC_Counter_out;

    modport master (
        output in_valid, PC_Counter_output_in,
        output Instruction_memory_in, out_ready,
        input  in_ready, out_valid, PC_Counter_out
    );

    modport slave (
        input  in_valid, PC_Counter_output_in,
        input  Instruction_memory_in, out_ready,
        output in_ready, out_valid, PC_Counter_out
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular buffer with decode slicing.
// Define IF_ID_BYPASS_EN for a 0-cycle path when the buffer is empty.
module if_id_queue #(
    parameter int n     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_in,
    input  logic                     flush_in,
    if_id_queue_if.slave             bus,
    output logic [5:0]               Op_code_out,
    output logic [4:0]               Read_Reg_1_out,
    output logic [4:0]               IF_ID_Rs_out,
    output logic [4:0]               Read_Reg_2_out,
    output logic [4:0]               IF_ID_Rt_out,
    output logic [4:0]               IF_ID_Rd_out,
    output logic [15:0]              sign_extend_input_out,
    output logic [25:0]              Jump_Offset_out,
    output logic [4:0]               Rs_Hazard_out,
    output logic [4:0]               Rt_Hazard_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [n-1:0] pc;
        logic [31:0]  instr;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          bypass;
    entry_t        in_e;
    entry_t        head_e;
    entry_t        sel_e;

    assign in_e         = '{pc: bus.PC_Counter_output_in,
                            instr: bus.Instruction_memory_in};
    assign bus.in_ready = (count != CW'(DEPTH));

`ifdef IF_ID_BYPASS_EN
    assign bypass = reset_in && (count == '0) && bus.in_valid && !flush_in;
`else
    assign bypass = 1'b0;
`endif

    assign bus.out_valid = (count != '0) || bypass;
    assign pop  = (count != '0) && bus.out_ready && !flush_in;
    // a bypassed word taken by decode never enters the buffer
    assign push = bus.in_valid && bus.in_ready && !flush_in
                  && !(bypass && bus.out_ready);

    assign head_e = bypass ? in_e : mem[head];
    assign sel_e  = bus.out_valid ? head_e : '0;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= in_e;
    end

    assign bus.PC_Counter_out     = sel_e.pc;
    assign Op_code_out            = sel_e.instr[31:26];
    assign Read_Reg_1_out         = sel_e.instr[25:21];
    assign IF_ID_Rs_out           = sel_e.instr[25:21];
    assign Read_Reg_2_out         = sel_e.instr[20:16];
    assign IF_ID_Rt_out           = sel_e.instr[20:16];
    assign IF_ID_Rd_out           = sel_e.instr[15:11];
    assign sign_extend_input_out  = sel_e.instr[15:0];
    assign Jump_Offset_out        = sel_e.instr[25:0];
    assign Rs_Hazard_out          = sel_e.instr[25:21];
    assign Rt_Hazard_out          = sel_e.instr[20:16];
    assign count_out              = count;
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: reset, fill/stall, flush, wrap, bypass.
module tb_if_id_queue;
    localparam int N     = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic tog   = 1'b0;

    if_id_queue_if #(.n(N)) bus ();

    logic [5:0]    op;
    logic [4:0]    rr1, rs, rr2, rt, rd, rsh, rth;
    logic [15:0]   imm;
    logic [25:0]   jmp;
    logic [CW-1:0] cnt;

    if_id_queue #(.n(N), .DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .reset_in              (rst_n),
        .flush_in              (flush),
        .bus                   (bus),
        .Op_code_out           (op),
        .Read_Reg_1_out        (rr1),
        .IF_ID_Rs_out          (rs),
        .Read_Reg_2_out        (rr2),
        .IF_ID_Rt_out          (rt),
        .IF_ID_Rd_out          (rd),
        .sign_extend_input_out (imm),
        .Jump_Offset_out       (jmp),
        .Rs_Hazard_out         (rsh),
        .Rt_Hazard_out         (rth),
        .count_out             (cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    ent_t        sb[$];
    logic [31:0] dlv[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor: compare head, then advance the model
    always @(negedge clk) begin
        ent_t h;
        bit   hv;
        bit   pu;
        if (!rst_n) begin
            sb.delete();
        end else begin
            hv = (sb.size() != 0);
            h  = hv ? sb[0] : '0;
`ifdef IF_ID_BYPASS_EN
            if (!hv && bus.in_valid && !flush) begin
                hv = 1'b1;
                h  = '{bus.PC_Counter_output_in, bus.Instruction_memory_in};
            end
`endif
            check("out_valid", bus.out_valid, hv);
            check("pc", bus.PC_Counter_out, h.pc);
            check("op", op, h.instr[31:26]);
            check("rr1", rr1, h.instr[25:21]);
            check("rs", rs, h.instr[25:21]);
            check("rr2", rr2, h.instr[20:16]);
            check("rt", rt, h.instr[20:16]);
            check("rd", rd, h.instr[15:11]);
            check("imm", imm, h.instr[15:0]);
            check("jmp", jmp, h.instr[25:0]);
            check("rs_haz", rsh, h.instr[25:21]);
            check("rt_haz", rth, h.instr[20:16]);
            check("count", cnt, sb.size());
            check("in_ready", bus.in_ready, sb.size() != DEPTH);
            if (flush) begin
                sb.delete();
            end else begin
                pu = bus.in_valid && (sb.size() != DEPTH);
                if (hv && bus.out_ready) begin
                    dlv.push_back(h.pc);
                    if (sb.size() != 0) void'(sb.pop_front());
                    else pu = 1'b0;
                end
                if (pu)
                    sb.push_back('{bus.PC_Counter_output_in,
                                   bus.Instruction_memory_in});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) bus.out_ready = ~bus.out_ready;
    endtask

    task automatic offer(logic [31:0] pc, logic [31:0] ins);
        int b = 0;
        bus.in_valid              = 1'b1;
        bus.PC_Counter_output_in  = pc;
        bus.Instruction_memory_in = ins;
        while (!bus.in_ready && b < 50) begin
            step();
            b++;
        end
        check("accept_timeout", b < 50, 1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && b < 50) begin
            step();
            b++;
        end
        check("drain_timeout", b < 50, 1);
    endtask

    initial begin
        bus.in_valid              = 1'b1;
        bus.out_ready             = 1'b1;
        bus.PC_Counter_output_in  = 32'h4;
        bus.Instruction_memory_in = 32'h012A4020;

        // reset with fetch presenting a word
        step();
        step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_op", op, 0);
        check("rst_rs", rs, 0);
        check("rst_imm", imm, 0);
        check("rst_jmp", jmp, 0);
        check("rst_pc", bus.PC_Counter_out, 0);
        check("rst_count", cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("rst_nothing_stored", bus.out_valid, 0);

        // single push
`ifdef IF_ID_BYPASS_EN
        bus.out_ready = 1'b0;
`endif
        offer(32'h4, 32'h012A4020);
        check("sp_valid", bus.out_valid, 1);
        check("sp_op", op, 0);
        check("sp_rs", rs, 9);
        check("sp_rt", rt, 10);
        check("sp_rd", rd, 8);
        check("sp_imm", imm, 16'h4020);
        check("sp_jmp", jmp, 26'h12A4020);
        check("sp_pc", bus.PC_Counter_out, 32'h4);
        bus.out_ready = 1'b1;
        step();
        check("sp_popped", bus.out_valid, 0);
        check("sp_rs_haz0", rsh, 0);

        // stall fill, third word held by fetch
        dlv.delete();
        bus.out_ready = 1'b0;
        offer(32'h4, 32'h20080001);
        offer(32'h8, 32'h20090002);
        check("fill_count", cnt, 2);
        check("fill_in_ready", bus.in_ready, 0);
        bus.in_valid              = 1'b1;
        bus.PC_Counter_output_in  = 32'hC;
        bus.Instruction_memory_in = 32'h012A5820;
        step();
        step();
        check("fill_held_count", cnt, 2);
        bus.out_ready = 1'b1;
        step();
        check("fill_ready_rise", bus.in_ready, 1);
        offer(32'hC, 32'h012A5820);
        drain();
        check("fill_dlv_n", dlv.size(), 3);
        if (dlv.size() == 3) begin
            check("fill_dlv0", dlv[0], 32'h4);
            check("fill_dlv1", dlv[1], 32'h8);
            check("fill_dlv2", dlv[2], 32'hC);
        end

        // flush with concurrent push and pop
        bus.out_ready = 1'b0;
        offer(32'h10, 32'h8D2A0004);
        offer(32'h14, 32'hAD2A0008);
        bus.in_valid              = 1'b1;
        bus.PC_Counter_output_in  = 32'h18;
        bus.Instruction_memory_in = 32'h11290003;
        bus.out_ready             = 1'b1;
        flush                     = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_count", cnt, 0);
        check("fl_valid", bus.out_valid, 0);
        check("fl_rs_haz", rsh, 0);
        offer(32'h40, 32'h08000010);
        check("fl_push_after", cnt, 1);
        drain();

        // pointer wrap with out_ready toggling
        dlv.delete();
        tog = 1'b1;
        for (int i = 0; i < 10; i++)
            offer(32'h100 + 32'(4 * i), $urandom);
        tog = 1'b0;
        drain();
        check("wrap_dlv_n", dlv.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < dlv.size())
                check("wrap_order", dlv[i], 32'h100 + 32'(4 * i));

        // asynchronous reset while holding entries
        bus.out_ready = 1'b0;
        offer(32'h200, 32'h012A4020);
        offer(32'h204, 32'h012A4020);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", cnt, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        check("arst_discarded", bus.out_valid, 0);

`ifdef IF_ID_BYPASS_EN
        bus.out_ready             = 1'b1;
        bus.in_valid              = 1'b1;
        bus.PC_Counter_output_in  = 32'h300;
        bus.Instruction_memory_in = 32'h8D2A0004;
        #1;
        check("byp_valid", bus.out_valid, 1);
        check("byp_pc", bus.PC_Counter_out, 32'h300);
        check("byp_rs", rs, 9);
        step();
        bus.in_valid = 1'b0;
        check("byp_count", cnt, 0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID pipeline stage that buffers up to DEPTH fetched instructions between the fetch unit and the decode stage of the 32-bit MIPS pipeline. It uses a valid/ready handshake on both sides, flushes synchronously on branch or jump redirect, and slices the head instruction into decode and hazard fields. It replaces the single-entry IF_ID register, so fetch can run ahead while decode stalls.

## Interface
Parameters:
- n, 32: PC width in bits. Instruction width is fixed at 32.
- DEPTH, 2: number of buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- flush_in  in  1  synchronous flush on branch or jump redirect.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept an instruction.
- PC_Counter_output_in  in  n  PC+4 of the fetched instruction.
- Instruction_memory_in  in  32  fetched instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode accepts the head entry; low means stall.
- PC_Counter_out  out  n  PC of the head entry.
- Op_code_out  out  6  head instruction bits [31:26].
- Read_Reg_1_out, IF_ID_Rs_out  out  5  head instruction bits [25:21].
- Read_Reg_2_out, IF_ID_Rt_out  out  5  head instruction bits [20:16].
- IF_ID_Rd_out  out  5  head instruction bits [15:11].
- sign_extend_input_out  out  16  head instruction bits [15:0].
- Jump_Offset_out  out  26  head instruction bits [25:0].
- Rs_Hazard_out, Rt_Hazard_out  out  5  Rs and Rt for the hazard unit.
- count_out  out  clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer of {PC, instruction} entries, with a head pointer, a tail pointer and an occupancy count. Both pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH). It is purely combinational and does not depend on out_ready, so there is no pop-through when full.
- **Push:** happens when in_valid & in_ready & !flush_in. The entry is written at the tail and tail advances.
- **Pop:** happens when out_valid & out_ready & !flush_in. Head advances.
- **Simultaneous push and pop:** count stays the same and both pointers advance.
- **Flush:** when flush_in = 1, count and both pointers go to 0 on the next edge. Any push or pop in that cycle is discarded. Flush has priority over everything.
- **Output fields:**
  - out_valid = (count != 0).
  - When out_valid = 1, all field outputs and PC_Counter_out reflect the head entry.
  - When out_valid = 0, all field outputs, PC_Counter_out, Rs_Hazard_out and Rt_Hazard_out are driven to 0, which presents a NOP bubble to decode and the hazard unit.
- Rs_Hazard_out and Rt_Hazard_out equal IF_ID_Rs_out and IF_ID_Rt_out. Through the rule above, they are zeroed whenever out_valid = 0.
- **Reset:** when reset_in = 0, count and pointers clear immediately.
  - In reset: out_valid = 0, all field outputs = 0, count_out = 0, in_ready = 1.
  - Buffer contents are not cleared.
  - If reset asserts while the buffer holds entries, they are discarded immediately.

## Timing
- Without bypass, latency is 1 cycle: an entry pushed at edge k is visible with out_valid = 1 after edge k.
- Fully pipelined throughput: one push and one pop per cycle.
- With out_ready held at 0, the buffer fills in DEPTH cycles and in_ready falls after the DEPTH-th push edge.
- in_ready rises in the cycle after the first pop from full.
- flush_in asserted in cycle k: out_valid = 0 from edge k onward. A push at edge k+1 is accepted normally.
- Reset deassertion is synchronised externally. The first push is possible at the first edge after reset_in rises.

## Configuration
- IF_ID_BYPASS_EN defined: when count = 0 and in_valid = 1 and flush_in = 0, out_valid = 1 combinationally.
  - All fields decode Instruction_memory_in and PC_Counter_output_in directly, giving 0-cycle latency.
  - If out_ready = 1 in that cycle, the instruction is consumed and not stored, and count stays at 0.
  - If out_ready = 0, it is stored as a normal push.
- IF_ID_BYPASS_EN undefined: no combinational input-to-output path. All outputs except in_ready come from registers or the buffer.

## Test plan
- **Reset:** reset_in = 0 with in_valid = 1 and instruction 0x012A4020 → out_valid = 0, all fields 0, count_out = 0, in_ready = 1; no entry stored.
- **Single push (bypass off):** PC 0x00000004, instruction 0x012A4020, out_ready = 1 → next cycle out_valid = 1, Op = 0, Rs = 9, Rt = 10, Rd = 8, imm = 0x4020, Jump = 0x12A4020; popped one cycle later, then out_valid = 0.
- **Stall fill:** out_ready = 0, push 3 instructions with DEPTH = 2 → count_out = 2 and in_ready = 0 after 2 edges; third held by fetch; out_ready = 1 → in-order delivery of all 3, PCs 4, 8, 0xC.
- **Flush:** count = 2 and a concurrent push and pop with flush_in = 1 → count_out = 0 and out_valid = 0 next cycle; Rs_Hazard_out = 0.
- **Pointer wrap:** stream 10 instructions with out_ready toggling every cycle → delivered in exact order, with no loss or duplication.
- **Bypass (IF_ID_BYPASS_EN):** empty buffer, in_valid = 1, out_ready = 1 → same-cycle out_valid = 1 with matching fields; count_out stays 0.
